instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction-fetch stage directly upstream of the immediate sign extender and decode logic. Owns the program counter, issues one request at a time to instruction memory, and tolerates memory wait states. It holds the returned instruction word steady for decode/sign-extension until the consumer accepts it. On acceptance it advances the PC to PC+4, or to PC+ImmExt when a branch or jump is taken, using the extended immediate fed back from the sign extender.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset; must be word-aligned.
- TIMEOUT_CYCLES, 16: fetch watchdog limit in cycles (range 1..255); used only with FETCH_TIMEOUT_EN.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  imem_rdata valid this cycle; honoured only in FETCH.
- imem_rdata  in  32  instruction word from memory.
- inst_valid  out  1  inst/pc/pc_plus4 hold a valid instruction.
- inst  out  32  instruction word; drives the sign extender Inst input.
- pc  out  32  address of inst.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- inst_ready  in  1  consumer accepts inst this cycle.
- pc_src  in  1  1 = take branch/jump for the accepted instruction.
- imm_ext  in  32  extended immediate for the accepted instruction.
- fetch_err  out  1  sticky error; fetching halted until reset.
- err_code  out  2  00 none, 01 misaligned target, 10 memory timeout.

## Operation
- FSM states: IDLE, FETCH, HOLD, TRAP.
- IDLE: entered on reset. Advances unconditionally to FETCH on the first clock edge after rst deasserts.
- FETCH:
  - Outputs imem_req=1 and imem_addr=fetch_pc.
  - On imem_ack=1: capture imem_rdata into inst, set pc=fetch_pc, set inst_valid=1, go to HOLD.
- HOLD:
  - imem_req=0; inst, pc and pc_plus4 are held stable.
  - On inst_ready=1, next_pc = pc_src ? pc + imm_ext : pc + 4. Arithmetic is 32-bit and wraps modulo 2^32.
  - If next_pc[1:0] != 00: go to TRAP with err_code=01.
  - Otherwise: clear inst_valid, set fetch_pc=next_pc, go to FETCH.
- TRAP:
  - imem_req=0, inst_valid=0, fetch_err=1, err_code held.
  - Exit only via rst.
- pc_src and imm_ext are sampled only when inst_valid && inst_ready; ignored otherwise.
- imem_ack outside FETCH is ignored; no state change.
- At most one memory request is outstanding at any time.

## Timing
- Reset values (asynchronous): state IDLE; imem_req 0; imem_addr RESET_PC; fetch_pc RESET_PC; inst_valid 0; inst 32'h0000_0013 (NOP); pc RESET_PC; pc_plus4 RESET_PC+4; fetch_err 0; err_code 00.
- imem_ack may rise in the same cycle imem_req first rises (zero-wait memory). Data is captured at that edge, and inst_valid=1 the next cycle.
- Best-case throughput: 2 cycles per instruction (1 FETCH + 1 HOLD with inst_ready=1).
- Each wait state adds 1 cycle in FETCH.
- Consumer backpressure: HOLD persists for as long as inst_ready=0; outputs are unchanged.
- rst asserted mid-FETCH: request drops immediately. A late ack after rst release, while in IDLE, is ignored.
- Wrap: pc=32'hFFFF_FFFC accepted with pc_src=0 fetches 32'h0000_0000.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - An 8-bit counter clears on FETCH entry and increments each FETCH cycle without imem_ack.
  - When the count reaches TIMEOUT_CYCLES without ack, the FSM goes to TRAP with err_code=10, and imem_req drops the next cycle.
  - An ack arriving in the same cycle the limit is reached wins: normal capture.
- FETCH_TIMEOUT_EN undefined: no counter; FETCH waits indefinitely; err_code=10 never produced.

## Test plan
- Reset release with RESET_PC=0, zero-wait memory returning 32'h00500093, inst_ready=1 constant -> imem_addr sequence 0,4,8; inst=32'h00500093 with pc=0 and pc_plus4=4; valid every second cycle.
- 3 wait states on the fetch of address 8 -> imem_addr=8 stable for 4 cycles; inst_valid rises 1 cycle after ack.
- Branch at pc=16 with pc_src=1 and imm_ext=32'hFFFF_FFF8 -> next imem_addr=8. With imm_ext=32'h0000_0006 -> TRAP, fetch_err=1, err_code=01, no further imem_req.
- inst_ready=0 for 5 cycles in HOLD with imem_ack toggling -> inst/pc unchanged; no imem_req; no state change.
- rst pulsed in FETCH, ack 1 cycle after release -> outputs return to reset values; ack ignored; next imem_addr=RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> TRAP after 4 FETCH cycles, err_code=10. Without the macro -> imem_req stays 1 for 100+ cycles.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time, holds the word for decode.
// Optional fetch watchdog is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        inst_ready,
    input  logic        pc_src,
    input  logic [31:0] imm_ext,
    output logic        fetch_err,
    output logic [1:0]  err_code
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    generate
        if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
            $error("RESET_PC must be word-aligned");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [1:0]  r_err_code;
    logic [1:0]  w_err_code_nxt;
    logic [31:0] w_next_pc;
    logic        w_to_expire;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] r_to_cnt;

    // Counter sits at zero outside FETCH, so it is cleared on every FETCH entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != FETCH) begin
            r_to_cnt <= '0;
        end else if (!imem_ack) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_to_expire = (r_state == FETCH) && !imem_ack &&
                         ((32'(r_to_cnt) + 32'd1) >= TIMEOUT_CYCLES);
`else
    assign w_to_expire = 1'b0;
`endif

    assign w_next_pc = pc_src ? (r_pc + imm_ext) : (r_pc + 32'd4);

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_inst_nxt     = r_inst;
        w_pc_nxt       = r_pc;
        w_err_code_nxt = r_err_code;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                // A same-cycle ack beats the watchdog.
                if (imem_ack) begin
                    w_inst_nxt  = imem_rdata;
                    w_pc_nxt    = r_fetch_pc;
                    w_state_nxt = HOLD;
                end else if (w_to_expire) begin
                    w_err_code_nxt = 2'b10;
                    w_state_nxt    = TRAP;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_err_code_nxt = 2'b01;
                        w_state_nxt    = TRAP;
                    end else begin
                        w_fetch_pc_nxt = w_next_pc;
                        w_state_nxt    = FETCH;
                    end
                end
            end
            TRAP: begin
                w_state_nxt = TRAP;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_inst     <= NOP_INST;
            r_pc       <= RESET_PC;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_pc       <= w_pc_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    assign imem_req   = (r_state == FETCH);
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_state == HOLD);
    assign inst       = r_inst;
    assign pc         = r_pc;
    assign pc_plus4   = r_pc + 32'd4;
    assign fetch_err  = (r_state == TRAP);
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: bench-side memory and PC model, expected words queued at ack.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] imm_ext = '0;
    logic        fetch_err;
    logic [1:0]  err_code;

    instr_fetch_unit #(
        .RESET_PC      (RESET_PC),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst      (inst),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .inst_ready(inst_ready),
        .pc_src    (pc_src),
        .imm_ext   (imm_ext),
        .fetch_err (fetch_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    int unsigned p_wait[8];
    int unsigned p_stall[8];
    logic        p_src[8];
    logic [31:0] p_imm[8];
    logic [31:0] m_fetch_pc;
    bit          m_trap;
    int unsigned accept_cyc;
    int unsigned ack_cyc;
    bit          accept_valid;
    int unsigned req_cnt;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[23:0], 8'h00};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 8; i++) begin
            p_wait[i]  = 0;
            p_stall[i] = 0;
            p_src[i]   = 1'b0;
            p_imm[i]   = 32'h0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; pc_src = 1'b0; imm_ext = '0; imem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        check32("rst_req",      32'(imem_req),   32'd0);
        check32("rst_addr",     imem_addr,       RESET_PC);
        check32("rst_valid",    32'(inst_valid), 32'd0);
        check32("rst_inst",     inst,            NOP_INST);
        check32("rst_pc",       pc,              RESET_PC);
        check32("rst_pc_plus4", pc_plus4,        RESET_PC + 32'd4);
        check32("rst_err",      32'(fetch_err),  32'd0);
        check32("rst_code",     32'(err_code),   32'd0);
        sb_q.delete();
        m_fetch_pc   = RESET_PC;
        m_trap       = 1'b0;
        rst          = 1'b0;
        accept_cyc   = cyc;
        accept_valid = 1'b1;
    endtask

    // Drives memory and consumer per the p_* program; returns at the n_instr-th acceptance or a trap.
    task automatic run_program(input int unsigned n_instr, input int unsigned budget);
        int unsigned idx = 0, wait_left = 0, stall_left = 0, used = 0, reqs = 0;
        bit          prev_valid = 1'b0, req_active = 1'b0;
        sb_t         cur = '0;
        logic [31:0] nxt;
        while (used < budget) begin
            @(negedge clk);
            used++;
            imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; inst_ready = 1'b0;
            pc_src = 1'b1; imm_ext = 32'h0000_0003;
            if (inst_valid) begin
                check32("hold_no_req", 32'(imem_req), 32'd0);
                if (!prev_valid) begin
                    check32("valid_lat", cyc - ack_cyc, 32'd1);
                    if (sb_q.size() == 0) check32("sb_underflow", 32'(sb_q.size()), 32'd1);
                    else cur = sb_q.pop_front();
                    stall_left = p_stall[idx];
                end
                check32("inst",     inst,     cur.data);
                check32("pc",       pc,       cur.addr);
                check32("pc_plus4", pc_plus4, cur.addr + 32'd4);
                if (stall_left > 0) begin
                    stall_left--;
                    imem_ack   = stall_left[0];
                    imem_rdata = 32'hBAD0_0000 ^ stall_left;
                end else begin
                    inst_ready = 1'b1; pc_src = p_src[idx]; imm_ext = p_imm[idx];
                    nxt = p_src[idx] ? cur.addr + p_imm[idx] : cur.addr + 32'd4;
                    idx++;
                    accept_cyc   = cyc;
                    accept_valid = 1'b1;
                    if (nxt[1:0] != 2'b00) begin
                        m_trap = 1'b1;
                        return;
                    end
                    m_fetch_pc = nxt;
                    if (idx == n_instr) return;
                end
            end else if (imem_req) begin
                check32("imem_addr", imem_addr, m_fetch_pc);
                if (!req_active) begin
                    req_active = 1'b1;
                    wait_left  = p_wait[idx];
                    reqs       = 0;
                    if (accept_valid) check32("req_lat", cyc - accept_cyc, 32'd1);
                    accept_valid = 1'b0;
                end
                reqs++;
                if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = memword(m_fetch_pc);
                    sb_q.push_back({m_fetch_pc, memword(m_fetch_pc)});
                    check32("req_cycles", reqs, p_wait[idx] + 1);
                    ack_cyc    = cyc;
                    req_active = 1'b0;
                end else begin
                    wait_left--;
                end
            end else begin
                check32("fsm_busy", 32'(imem_req), 32'd1);
            end
            prev_valid = inst_valid;
        end
        check32("budget_instr", idx, n_instr);
    endtask

    task automatic check_trap(input logic [1:0] code, input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            imem_ack = ~imem_ack; inst_ready = 1'b1; pc_src = 1'b0; imm_ext = 32'h4;
            check32("trap_req",   32'(imem_req),   32'd0);
            check32("trap_valid", 32'(inst_valid), 32'd0);
            check32("trap_err",   32'(fetch_err),  32'd1);
            check32("trap_code",  32'(err_code),   32'(code));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential, wait states, backward branch, stall, misaligned branch.
        do_reset();
        clear_prog();
        p_wait[2]  = 3;
        p_src[4]   = 1'b1; p_imm[4] = 32'hFFFF_FFF8;
        p_stall[6] = 5;
        p_src[7]   = 1'b1; p_imm[7] = 32'h0000_0006;
        run_program(8, 200);
        check_trap(2'b01, 8);

        // Reset pulse mid-FETCH with a late ack during IDLE.
        do_reset();
        clear_prog();
        run_program(2, 50);
        @(negedge clk);
        imem_ack = 1'b0; inst_ready = 1'b0;
        check32("mid_req",  32'(imem_req), 32'd1);
        check32("mid_addr", imem_addr,     32'h0000_0008);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check32("pulse_req",   32'(imem_req),   32'd0);
        check32("pulse_valid", 32'(inst_valid), 32'd0);
        check32("pulse_addr",  imem_addr,       RESET_PC);
        check32("pulse_pc",    pc,              RESET_PC);
        check32("pulse_inst",  inst,            NOP_INST);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        imem_ack = 1'b0;
        check32("late_ack_req",   32'(imem_req),   32'd1);
        check32("late_ack_addr",  imem_addr,       RESET_PC);
        check32("late_ack_valid", 32'(inst_valid), 32'd0);
        check32("late_ack_inst",  inst,            NOP_INST);

        // Wrap-around: branch to 0xFFFFFFFC, then sequential to 0.
        sb_q.delete();
        m_fetch_pc   = RESET_PC;
        accept_valid = 1'b0;
        clear_prog();
        p_src[0] = 1'b1; p_imm[0] = 32'hFFFF_FFFC;
        run_program(3, 50);

        // Fetch watchdog behaviour with no ack ever returned.
        do_reset();
        req_cnt = 0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req) req_cnt++;
        end
        check32("to_req_cycles", req_cnt,         32'd4);
        check32("to_err",        32'(fetch_err),  32'd1);
        check32("to_code",       32'(err_code),   32'd2);
`else
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req && imem_addr == RESET_PC) req_cnt++;
        end
        check32("noto_req_cycles", req_cnt,        32'd120);
        check32("noto_err",        32'(fetch_err), 32'd0);
        check32("noto_code",       32'(err_code),  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
